axi_b_stream_tap: RTL and testbench
===================================

# axi_b_stream_tap

Parametrised AXI write-response (B channel) tap for the EthHelper AXI-to-stream path. It forwards B handshakes between the master-side and slave-side ports and copies every completed response into an internal FIFO. It drains the FIFO as bounded bursts on the shared submodule stream interface (valid/in_progress/last/length/data) so the stream arbiter can serialise B-channel traffic with the other channel submodules. Overflow is either back-pressured or dropped and counted, selected by parameter.

## Interface
- DATA_WIDTH, 128, stream word width; must be ≥ ID_WIDTH+2+USER_WIDTH+16
- ADDR_WIDTH, 64, unused, kept for port-list uniformity with sibling submodules
- ID_WIDTH, 32, bid width
- BURST_LEN, 8, max records per stream transaction, 1..63
- LOCK_WIDTH, 2, unused, uniformity
- USER_WIDTH, 64, buser width
- FIFO_DEPTH, 16, record FIFO entries, power of two ≥ 2
- BLOCK_ON_FULL, 1, 1 = stall B channel when FIFO full; 0 = pass through and drop record
- clk  in  1  single clock, all logic on rising edge
- resetn  in  1  synchronous reset, active low, sampled on rising clk edge
- ready  in  1  arbiter accepts current stream beat
- valid  out  1  current beat valid
- in_progress  out  1  burst under way; blocks other submodules
- last  out  1  final beat of burst
- submodule_transaction_length  out  6  beats in current/next burst
- data  out  DATA_WIDTH  stream record
- overflow_count  out  16  dropped records, saturating
- AXIM_bid/bresp/buser/bvalid  in  ID_WIDTH/2/USER_WIDTH/1  master-side response
- AXIM_bready  out  1
- AXIS_bid/bresp/buser/bvalid  out  ID_WIDTH/2/USER_WIDTH/1  slave-side response
- AXIS_bready  in  1

## Operation
- Pass-through: AXIS_bid/bresp/buser = AXIM_* combinationally. BLOCK_ON_FULL=1: AXIS_bvalid = AXIM_bvalid & !full, AXIM_bready = AXIS_bready & !full. BLOCK_ON_FULL=0: plain wires.
- Capture event = AXIM_bvalid & AXIM_bready (as driven). If !full: push record; else (mode 0 only) overflow_count += 1, saturating at 0xFFFF.
- Record layout: [ID_WIDTH-1:0]=bid; next 2 bits bresp; next USER_WIDTH bits buser; top 16 bits = seq; remaining bits 0. seq starts 0 after reset, increments per pushed record, wraps 0xFFFF→0.
- full/empty from count register (0..FIFO_DEPTH); full evaluated on registered count, no same-cycle pop bypass: full FIFO with pop this cycle still refuses push.
- data = FIFO head (combinational read of mem[rd_ptr]); pointers wrap modulo FIFO_DEPTH.
- FSM IDLE: in_progress=0; valid = !empty; length = min(count, BURST_LEN), 0 when empty; last = (length==1). Beat (valid&ready) pops head; if length>1, latch remaining = length-1 and go STREAM, else stay IDLE.
- FSM STREAM: in_progress=1, valid=1, length = latched burst length; each beat pops and decrements remaining; last when remaining==1; beat with last → IDLE. Records pushed mid-burst do not extend the burst.
- Simultaneous push and pop: count unchanged, both pointers advance.

## Timing
- Reset: FSM IDLE, pointers/count/seq/overflow_count = 0; valid, in_progress, last = 0, length = 0, data = mem[0] (don't care, 0 in sim); pass-through stays combinational during reset, but no capture occurs while resetn=0.
- Capture-to-valid latency: 1 cycle (record visible at head cycle after handshake).
- Beat throughput 1/cycle while ready high; ready low holds valid, data, last stable.
- Reset mid-burst: next cycle IDLE, FIFO emptied, in_progress=0; no last issued.

## Test plan
- Single response bid=0x5, bresp=2'b10, buser=0xAB -> next cycle valid=1, length=1, last=1, data[31:0]=0x5, data[33:32]=2, data[97:34]=0xAB, seq=0; ready -> empty, valid=0.
- 20 back-to-back responses, ready held low, FIFO_DEPTH=16, BLOCK_ON_FULL=1 -> AXIM_bready low from 17th; ready high -> bursts of 8,8 with in_progress spanning each, last on 8th beat, seq 0..15 in order; stalled 4 then accepted.
- Same with BLOCK_ON_FULL=0 -> all 20 pass through, overflow_count=4, streamed seq 0..15.
- Push and pop same cycle at count=3 -> count stays 3, order preserved.
- Ready toggling 1/0 during 5-record burst -> data/last stable while ready low, exactly 5 beats, last on 5th.
- resetn low during beat 3 of 8 -> in_progress=0, valid=0, overflow_count=0 next cycle.

Source files
------------

// File: rtl/axi_b_stream_tap.sv
// AXI B-channel tap: forwards write responses master->slave and copies each
// completed response into a FIFO that is drained as bounded stream bursts.
module axi_b_stream_tap #(
  parameter int DATA_WIDTH    = 128,
  parameter int ADDR_WIDTH    = 64,
  parameter int ID_WIDTH      = 32,
  parameter int BURST_LEN     = 8,
  parameter int LOCK_WIDTH    = 2,
  parameter int USER_WIDTH    = 64,
  parameter int FIFO_DEPTH    = 16,
  parameter int BLOCK_ON_FULL = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  ready,
  output logic                  valid,
  output logic                  in_progress,
  output logic                  last,
  output logic [5:0]            submodule_transaction_length,
  output logic [DATA_WIDTH-1:0] data,
  output logic [15:0]           overflow_count,
  input  logic [ID_WIDTH-1:0]   AXIM_bid,
  input  logic [1:0]            AXIM_bresp,
  input  logic [USER_WIDTH-1:0] AXIM_buser,
  input  logic                  AXIM_bvalid,
  output logic                  AXIM_bready,
  output logic [ID_WIDTH-1:0]   AXIS_bid,
  output logic [1:0]            AXIS_bresp,
  output logic [USER_WIDTH-1:0] AXIS_buser,
  output logic                  AXIS_bvalid,
  input  logic                  AXIS_bready
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, STREAM} state_t;

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [15:0]           r_seq;
  logic [15:0]           r_overflow;
  state_t                r_state;
  logic [5:0]            r_remaining;
  logic [5:0]            r_burst_len;

  state_t                w_state_next;
  logic [5:0]            w_remaining_next;
  logic [5:0]            w_burst_len_next;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_capture;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_pop;
  logic                  w_valid;
  logic                  w_in_progress;
  logic                  w_last;
  logic [5:0]            w_length;
  logic [5:0]            w_idle_len;
  logic [DATA_WIDTH-1:0] w_record;

  assign w_full  = (32'(r_count) == FIFO_DEPTH);
  assign w_empty = (r_count == '0);

  assign AXIS_bid   = AXIM_bid;
  assign AXIS_bresp = AXIM_bresp;
  assign AXIS_buser = AXIM_buser;

  // In blocking mode a full FIFO stalls the handshake in both directions.
  generate
    if (BLOCK_ON_FULL != 0) begin : g_block
      assign AXIS_bvalid = AXIM_bvalid & ~w_full;
      assign AXIM_bready = AXIS_bready & ~w_full;
    end else begin : g_pass
      assign AXIS_bvalid = AXIM_bvalid;
      assign AXIM_bready = AXIS_bready;
    end
  endgenerate

  assign w_capture = AXIM_bvalid & AXIM_bready;
  assign w_push    = w_capture & ~w_full;
  assign w_drop    = w_capture & w_full & (BLOCK_ON_FULL == 0);
  assign w_pop     = w_valid & ready;

  always_comb begin
    w_record = '0;
    w_record[ID_WIDTH-1:0] = AXIM_bid;
    w_record[ID_WIDTH+1:ID_WIDTH] = AXIM_bresp;
    w_record[ID_WIDTH+2+USER_WIDTH-1:ID_WIDTH+2] = AXIM_buser;
    w_record[DATA_WIDTH-1:DATA_WIDTH-16] = r_seq;
  end

  always_comb begin
    if (32'(r_count) >= BURST_LEN) w_idle_len = 6'(BURST_LEN);
    else                           w_idle_len = 6'(r_count);
  end

  // Burst length is frozen at the first beat so late pushes never extend it.
  always_comb begin
    w_state_next     = r_state;
    w_remaining_next = r_remaining;
    w_burst_len_next = r_burst_len;
    w_valid          = 1'b0;
    w_in_progress    = 1'b0;
    w_last           = 1'b0;
    w_length         = 6'd0;
    case (r_state)
      IDLE: begin
        w_valid  = ~w_empty;
        w_length = w_idle_len;
        w_last   = (w_idle_len == 6'd1);
        if (~w_empty && ready && (w_idle_len > 6'd1)) begin
          w_state_next     = STREAM;
          w_remaining_next = w_idle_len - 6'd1;
          w_burst_len_next = w_idle_len;
        end
      end
      STREAM: begin
        w_valid       = 1'b1;
        w_in_progress = 1'b1;
        w_length      = r_burst_len;
        w_last        = (r_remaining == 6'd1);
        if (ready) begin
          w_remaining_next = r_remaining - 6'd1;
          if (r_remaining == 6'd1) w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push && resetn) r_mem[r_wr_ptr] <= w_record;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_seq       <= '0;
      r_overflow  <= '0;
      r_remaining <= '0;
      r_burst_len <= '0;
    end else begin
      r_state     <= w_state_next;
      r_remaining <= w_remaining_next;
      r_burst_len <= w_burst_len_next;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_seq    <= r_seq + 16'd1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      if (w_drop && (r_overflow != 16'hFFFF)) r_overflow <= r_overflow + 16'd1;
    end
  end

  assign valid                        = w_valid;
  assign in_progress                  = w_in_progress;
  assign last                         = w_last;
  assign submodule_transaction_length = w_length;
  assign data                         = r_mem[r_rd_ptr];
  assign overflow_count               = r_overflow;

endmodule

// File: tb/tb_axi_b_stream_tap.sv
// Bench for axi_b_stream_tap: drives a blocking (index 0) and a dropping
// (index 1) instance side by side against a list-based reference model.
module tb_axi_b_stream_tap;

  localparam int DW = 128;
  localparam int IW = 32;
  localparam int UW = 64;
  localparam int BL = 8;
  localparam int FD = 16;

  logic clk = 1'b0;
  logic resetn;

  logic          ready    [2];
  logic [IW-1:0] mBid     [2];
  logic [1:0]    mBresp   [2];
  logic [UW-1:0] mBuser   [2];
  logic          mBvalid  [2];
  logic          sBready  [2];
  logic          valid    [2];
  logic          inProg   [2];
  logic          last     [2];
  logic [5:0]    len      [2];
  logic [DW-1:0] data     [2];
  logic [15:0]   ovf      [2];
  logic          mBready  [2];
  logic [IW-1:0] sBid     [2];
  logic [1:0]    sBresp   [2];
  logic [UW-1:0] sBuser   [2];
  logic          sBvalid  [2];

  logic [DW-1:0] modelRec [2][FD];
  int            modelSize[2];
  bit            inBurst  [2];
  int            burstLen [2];
  int            beatsLeft[2];
  logic [15:0]   modelSeq [2];
  logic [15:0]   modelOvf [2];
  bit            hsDone   [2];
  int            respLeft [2];
  int            validPct;
  int            numChecks = 0;
  int            numErrors = 0;

  // Free-running 100 MHz clock shared by both instances
  always #5 clk = ~clk;

  // Instance 0 stalls the B channel when full, instance 1 drops and counts
  for (genvar g = 0; g < 2; g++) begin : gDut
    axi_b_stream_tap #(
      .DATA_WIDTH(DW), .ID_WIDTH(IW), .BURST_LEN(BL), .USER_WIDTH(UW),
      .FIFO_DEPTH(FD), .BLOCK_ON_FULL((g == 0) ? 1 : 0)
    ) dut (
      .clk(clk), .resetn(resetn), .ready(ready[g]), .valid(valid[g]),
      .in_progress(inProg[g]), .last(last[g]),
      .submodule_transaction_length(len[g]), .data(data[g]),
      .overflow_count(ovf[g]),
      .AXIM_bid(mBid[g]), .AXIM_bresp(mBresp[g]), .AXIM_buser(mBuser[g]),
      .AXIM_bvalid(mBvalid[g]), .AXIM_bready(mBready[g]),
      .AXIS_bid(sBid[g]), .AXIS_bresp(sBresp[g]), .AXIS_buser(sBuser[g]),
      .AXIS_bvalid(sBvalid[g]), .AXIS_bready(sBready[g])
    );
  end

  // Single point of comparison; counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    numChecks++;
    if (observed !== expected) begin
      numErrors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Fresh random payload for the next response of one instance
  task automatic newPayload(input int d);
    mBid[d]   = $urandom;
    mBresp[d] = 2'($urandom);
    mBuser[d] = {$urandom, $urandom};
  endtask

  task automatic modelClear(input int d);
    modelSize[d] = 0;
    inBurst[d]   = 0;
    burstLen[d]  = 0;
    beatsLeft[d] = 0;
    modelSeq[d]  = 16'd0;
    modelOvf[d]  = 16'd0;
  endtask

  // One clock: check outputs against the model mid-cycle, advance the model,
  // then update the response sources once the edge has passed
  task automatic applyStimulus();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      bit blk, full, eBready, eValid, eLast, pop, capture;
      int eLen;
      logic [DW-1:0] rec;
      blk     = (d == 0);
      full    = (modelSize[d] == FD);
      eBready = sBready[d] & !(blk & full);
      checkOutput($sformatf("bready%0d", d), mBready[d], eBready);
      checkOutput($sformatf("sBvalid%0d", d), sBvalid[d], mBvalid[d] & !(blk & full));
      checkOutput($sformatf("sBid%0d", d), sBid[d], mBid[d]);
      checkOutput($sformatf("sBresp%0d", d), sBresp[d], mBresp[d]);
      checkOutput($sformatf("sBuser%0d", d), sBuser[d], mBuser[d]);
      if (inBurst[d]) begin
        eValid = 1;
        eLen   = burstLen[d];
        eLast  = (beatsLeft[d] == 1);
      end else begin
        eValid = (modelSize[d] != 0);
        eLen   = (modelSize[d] < BL) ? modelSize[d] : BL;
        eLast  = (eLen == 1);
      end
      checkOutput($sformatf("valid%0d", d), valid[d], eValid);
      checkOutput($sformatf("inProg%0d", d), inProg[d], inBurst[d]);
      checkOutput($sformatf("len%0d", d), len[d], 128'(eLen));
      checkOutput($sformatf("last%0d", d), last[d], eLast);
      checkOutput($sformatf("ovf%0d", d), ovf[d], modelOvf[d]);
      if (eValid) checkOutput($sformatf("data%0d", d), data[d], modelRec[d][0]);

      hsDone[d] = 0;
      if (!resetn) begin
        modelClear(d);
      end else begin
        pop       = eValid & ready[d];
        capture   = mBvalid[d] & eBready;
        hsDone[d] = capture;
        if (pop) begin
          for (int k = 0; k < FD - 1; k++) modelRec[d][k] = modelRec[d][k+1];
          modelSize[d]--;
          if (inBurst[d]) begin
            beatsLeft[d]--;
            if (beatsLeft[d] == 0) inBurst[d] = 0;
          end else if (eLen > 1) begin
            inBurst[d]   = 1;
            burstLen[d]  = eLen;
            beatsLeft[d] = eLen - 1;
          end
        end
        if (capture) begin
          if (!full) begin
            rec = '0;
            rec[IW-1:0]        = mBid[d];
            rec[IW+1:IW]       = mBresp[d];
            rec[IW+UW+1:IW+2]  = mBuser[d];
            rec[DW-1:DW-16]    = modelSeq[d];
            modelRec[d][modelSize[d]] = rec;
            modelSize[d]++;
            modelSeq[d] = modelSeq[d] + 16'd1;
          end else if (!blk && modelOvf[d] != 16'hFFFF) begin
            modelOvf[d] = modelOvf[d] + 16'd1;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (hsDone[d]) begin
        respLeft[d]--;
        newPayload(d);
        mBvalid[d] = 1'b0;
      end
      if (!mBvalid[d] && respLeft[d] > 0 && $urandom_range(0, 99) < validPct)
        mBvalid[d] = 1'b1;
    end
  endtask

  task automatic loadResp(input int d, input logic [IW-1:0] bid,
                          input logic [1:0] bresp, input logic [UW-1:0] buser);
    mBid[d]     = bid;
    mBresp[d]   = bresp;
    mBuser[d]   = buser;
    mBvalid[d]  = 1'b1;
    respLeft[d] = 1;
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  // Accept everything until pending responses and both FIFOs are gone
  task automatic drainAll();
    int budget;
    validPct = 100;
    budget   = 400;
    for (int d = 0; d < 2; d++) begin
      ready[d]   = 1'b1;
      sBready[d] = 1'b1;
    end
    while ((respLeft[0] + respLeft[1] + modelSize[0] + modelSize[1]) != 0 && budget > 0) begin
      applyStimulus();
      budget--;
    end
    checkOutput("drainBudget", 128'(budget == 0), 128'(0));
    for (int d = 0; d < 2; d++) ready[d] = 1'b0;
  endtask

  initial begin
    resetn   = 1'b0;
    validPct = 100;
    for (int d = 0; d < 2; d++) begin
      ready[d]    = 1'b0;
      sBready[d]  = 1'b1;
      mBvalid[d]  = 1'b0;
      respLeft[d] = 0;
      newPayload(d);
      modelClear(d);
    end
    @(posedge clk);
    #1;
    runCycles(3);
    resetn = 1'b1;
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("rstValid%0d", d), valid[d], 1'b0);
      checkOutput($sformatf("rstLen%0d", d), len[d], 6'd0);
      checkOutput($sformatf("rstOvf%0d", d), ovf[d], 16'd0);
    end

    // Single response shows up one cycle after its handshake
    for (int d = 0; d < 2; d++) loadResp(d, 32'h5, 2'b10, 64'hAB);
    applyStimulus();
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("oneValid%0d", d), valid[d], 1'b1);
      checkOutput($sformatf("oneLen%0d", d), len[d], 6'd1);
      checkOutput($sformatf("oneLast%0d", d), last[d], 1'b1);
      checkOutput($sformatf("oneBid%0d", d), data[d][31:0], 32'h5);
      checkOutput($sformatf("oneBresp%0d", d), data[d][33:32], 2'd2);
      checkOutput($sformatf("oneBuser%0d", d), data[d][97:34], 64'hAB);
      checkOutput($sformatf("oneSeq%0d", d), data[d][127:112], 16'd0);
    end
    applyStimulus();
    for (int d = 0; d < 2; d++) ready[d] = 1'b1;
    applyStimulus();
    for (int d = 0; d < 2; d++) begin
      ready[d] = 1'b0;
      checkOutput($sformatf("oneEmpty%0d", d), valid[d], 1'b0);
    end

    // Twenty back-to-back responses with the stream stalled
    for (int d = 0; d < 2; d++) respLeft[d] = 20;
    runCycles(30);
    checkOutput("stallBready", mBready[0], 1'b0);
    checkOutput("dropBready", mBready[1], 1'b1);
    checkOutput("dropOvf", ovf[1], 16'd4);
    checkOutput("stallLen", len[0], 6'd8);
    drainAll();
    checkOutput("dropOvfFinal", ovf[1], 16'd4);
    checkOutput("blockOvfFinal", ovf[0], 16'd0);

    // Push and pop together while three records are queued
    for (int d = 0; d < 2; d++) respLeft[d] = 3;
    runCycles(5);
    for (int d = 0; d < 2; d++) begin
      respLeft[d] = 1;
      mBvalid[d]  = 1'b1;
      ready[d]    = 1'b1;
    end
    applyStimulus();
    for (int d = 0; d < 2; d++) ready[d] = 1'b0;
    runCycles(3);
    drainAll();

    // Five-record burst with ready toggling every cycle
    for (int d = 0; d < 2; d++) respLeft[d] = 5;
    runCycles(7);
    for (int i = 0; i < 12; i++) begin
      for (int d = 0; d < 2; d++) ready[d] = (i % 2 == 0);
      applyStimulus();
    end
    drainAll();

    // Reset lands on the third beat of an eight-beat burst
    for (int d = 0; d < 2; d++) respLeft[d] = 8;
    runCycles(10);
    for (int d = 0; d < 2; d++) ready[d] = 1'b1;
    runCycles(2);
    resetn = 1'b0;
    applyStimulus();
    resetn = 1'b1;
    for (int d = 0; d < 2; d++) begin
      ready[d] = 1'b0;
      checkOutput($sformatf("midRstProg%0d", d), inProg[d], 1'b0);
      checkOutput($sformatf("midRstValid%0d", d), valid[d], 1'b0);
      checkOutput($sformatf("midRstOvf%0d", d), ovf[d], 16'd0);
    end

    // Random traffic: slow consumer first so overflow occurs, then fast
    validPct = 60;
    for (int d = 0; d < 2; d++) respLeft[d] = 100000;
    for (int i = 0; i < 1500; i++) begin
      for (int d = 0; d < 2; d++) begin
        ready[d]   = (i < 700) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
        sBready[d] = ($urandom_range(0, 3) != 0);
      end
      applyStimulus();
    end
    for (int d = 0; d < 2; d++) respLeft[d] = mBvalid[d] ? 1 : 0;
    drainAll();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numChecks, numErrors);
    $finish;
  end

endmodule
